// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier for the {sign, exp, frac} format.
// Round-to-nearest-even, flush-to-zero, and exception flags travel with each result.
module fp_mul_pipe #(
  parameter int EXPONENT_BITS = 8,
  parameter int FRACTION_BITS = 23,
  localparam int W = 1 + EXPONENT_BITS + FRACTION_BITS
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);

  localparam int E    = EXPONENT_BITS;
  localparam int F    = FRACTION_BITS;
  localparam int EW   = E + 2;
  localparam int MW   = F + 1;
  localparam int PW   = 2 * F + 2;
  localparam int BIAS = (1 << (E - 1)) - 1;
  localparam int EMAX = (1 << E) - 1;
  localparam logic [W-1:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(F-1){1'b0}}};

  // Handshake: a transfer happens on an edge where valid && ready. One enable
  // moves the whole pipeline; it stalls only while a result waits unaccepted.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // ---------------- S1: unpack / classify ----------------
  logic         sa, sb, sign_d;
  logic [E-1:0] ea, eb;
  logic [F-1:0] fa, fb;
  logic         a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic         sp_d, inv_d;
  logic [W-1:0] sp_res_d;
  logic signed [EW-1:0] e_d;

  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;
  assign sign_d = sa ^ sb;

  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) && (fa == '0);
  assign b_inf  = (&eb) && (fb == '0);
  assign a_nan  = (&ea) && (fa != '0);
  assign b_nan  = (&eb) && (fb != '0);

  assign e_d = $signed({2'b00, ea}) + $signed({2'b00, eb}) - $signed(EW'(BIAS));

  // Special operands bypass the arithmetic; precedence is NaN, then Inf, then zero.
  always_comb begin
    sp_d     = 1'b0;
    inv_d    = 1'b0;
    sp_res_d = '0;
    if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
      sp_d     = 1'b1;
      sp_res_d = QNAN;
      inv_d    = (a_zero && b_inf) || (a_inf && b_zero);
    end else if (a_inf || b_inf) begin
      sp_d     = 1'b1;
      sp_res_d = {sign_d, {E{1'b1}}, {F{1'b0}}};
    end else if (a_zero || b_zero) begin
      sp_d     = 1'b1;
      sp_res_d = {sign_d, {(W-1){1'b0}}};
    end
  end

  logic                 s1_v, s1_sign, s1_sp, s1_inv;
  logic [W-1:0]         s1_sp_res;
  logic [MW-1:0]        s1_ma, s1_mb;
  logic signed [EW-1:0] s1_e;

  logic                 s2_v, s2_sign, s2_sp, s2_inv;
  logic [W-1:0]         s2_sp_res;
  logic [PW-1:0]        s2_p;
  logic signed [EW-1:0] s2_e;

  // ---------------- S3: normalise / round / pack ----------------
  logic [PW-1:0]        pn;
  logic [MW-1:0]        mant;
  logic [MW:0]          mant_r;
  logic                 guard, sticky, inc;
  logic [F-1:0]         frac_r;
  logic signed [EW-1:0] e_n;
  logic [W-1:0]         res_d;
  logic [3:0]           flags_d;

  assign pn     = s2_p[PW-1] ? s2_p : {s2_p[PW-2:0], 1'b0};
  assign mant   = pn[PW-1 -: MW];
  assign guard  = pn[PW-1-MW];
  assign sticky = |pn[PW-2-MW:0];
  assign inc    = guard && (sticky || mant[0]);
  assign mant_r = {1'b0, mant} + {{MW{1'b0}}, inc};
  // A rounding carry-out means the mantissa wrapped to 1.000..0.
  assign frac_r = mant_r[MW] ? mant_r[MW-1:1] : mant_r[MW-2:0];
  assign e_n    = s2_e + $signed({{(EW-1){1'b0}}, s2_p[PW-1]})
                       + $signed({{(EW-1){1'b0}}, mant_r[MW]});

  always_comb begin
    res_d   = '0;
    flags_d = 4'b0000;
    if (s2_sp) begin
      res_d   = s2_sp_res;
      flags_d = {s2_inv, 3'b000};
    end else if (int'(e_n) >= EMAX) begin
      res_d   = {s2_sign, {E{1'b1}}, {F{1'b0}}};
      flags_d = 4'b0101;
    end else if (int'(e_n) <= 0) begin
      res_d   = {s2_sign, {(W-1){1'b0}}};
      flags_d = 4'b0011;
    end else begin
      res_d   = {s2_sign, e_n[E-1:0], frac_r};
      flags_d = {3'b000, guard | sticky};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_v      <= 1'b0;
      s1_sign   <= 1'b0;
      s1_sp     <= 1'b0;
      s1_inv    <= 1'b0;
      s1_sp_res <= '0;
      s1_ma     <= '0;
      s1_mb     <= '0;
      s1_e      <= '0;
      s2_v      <= 1'b0;
      s2_sign   <= 1'b0;
      s2_sp     <= 1'b0;
      s2_inv    <= 1'b0;
      s2_sp_res <= '0;
      s2_p      <= '0;
      s2_e      <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= 4'b0000;
    end else if (en) begin
      s1_v      <= in_valid;
      s1_sign   <= sign_d;
      s1_sp     <= sp_d;
      s1_inv    <= inv_d;
      s1_sp_res <= sp_res_d;
      s1_ma     <= {1'b1, fa};
      s1_mb     <= {1'b1, fb};
      s1_e      <= e_d;
      s2_v      <= s1_v;
      s2_sign   <= s1_sign;
      s2_sp     <= s1_sp;
      s2_inv    <= s1_inv;
      s2_sp_res <= s1_sp_res;
      s2_p      <= PW'(s1_ma) * PW'(s1_mb);
      s2_e      <= s1_e;
      out_valid <= s2_v;
      result    <= res_d;
      flags     <= flags_d;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed testbench for fp_mul_pipe (single precision): latency, rounding,
// exceptions, specials, backpressure and reset flush, with an in-order scoreboard.
module tb_fp_mul_pipe;

  localparam int W = 32;

  logic         clock;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  fp_mul_pipe dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- scoreboard ----------------
  logic [W+3:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int out_idx = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drive, sample handshakes mid-cycle, advance one cycle.
  task automatic cyc(input logic v, input logic [W-1:0] xa, input logic [W-1:0] xb,
                     input logic [W-1:0] er, input logic [3:0] ef, input logic ordy);
    logic [W+3:0] e;
    in_valid  = v;
    a         = xa;
    b         = xb;
    out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      check($sformatf("sb_nonempty%0d", out_idx), 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("sb_result%0d", out_idx), 64'(result), 64'(e[W+3:4]));
        check($sformatf("sb_flags%0d", out_idx), 64'(flags), 64'(e[3:0]));
      end
      out_idx++;
    end
    if (v && in_ready) exp_q.push_back({er, ef});
    @(negedge clock);
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, '0, '0, '0, 4'h0, ordy);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      idle(1'b1);
      n++;
    end
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  logic [W-1:0] va[15], vb[15], vr[15];
  logic [3:0]   vf[15];

  initial begin
    va[0]  = 32'h3F800001; vb[0]  = 32'h3F800001; vr[0]  = 32'h3F800002; vf[0]  = 4'b0001;
    va[1]  = 32'h7F000000; vb[1]  = 32'h40000000; vr[1]  = 32'h7F800000; vf[1]  = 4'b0101;
    va[2]  = 32'h00800000; vb[2]  = 32'h3F000000; vr[2]  = 32'h00000000; vf[2]  = 4'b0011;
    va[3]  = 32'h00000000; vb[3]  = 32'h7F800000; vr[3]  = 32'h7FC00000; vf[3]  = 4'b1000;
    va[4]  = 32'h7FC00001; vb[4]  = 32'h3F800000; vr[4]  = 32'h7FC00000; vf[4]  = 4'b0000;
    va[5]  = 32'hBFC00000; vb[5]  = 32'h40000000; vr[5]  = 32'hC0400000; vf[5]  = 4'b0000;
    va[6]  = 32'h3FFFFFFF; vb[6]  = 32'h3FFFFFFF; vr[6]  = 32'h407FFFFE; vf[6]  = 4'b0001;
    va[7]  = 32'h3F800001; vb[7]  = 32'h3FC00000; vr[7]  = 32'h3FC00002; vf[7]  = 4'b0001;
    va[8]  = 32'h3F800003; vb[8]  = 32'h3FC00000; vr[8]  = 32'h3FC00004; vf[8]  = 4'b0001;
    va[9]  = 32'hFF000000; vb[9]  = 32'h40000000; vr[9]  = 32'hFF800000; vf[9]  = 4'b0101;
    va[10] = 32'hFF800000; vb[10] = 32'h40000000; vr[10] = 32'hFF800000; vf[10] = 4'b0000;
    va[11] = 32'h80000000; vb[11] = 32'h40000000; vr[11] = 32'h80000000; vf[11] = 4'b0000;
    va[12] = 32'h00000001; vb[12] = 32'h40000000; vr[12] = 32'h00000000; vf[12] = 4'b0000;
    va[13] = 32'h7F800000; vb[13] = 32'h7F800000; vr[13] = 32'h7F800000; vf[13] = 4'b0000;
    va[14] = 32'h7F800000; vb[14] = 32'h00000000; vr[14] = 32'h7FC00000; vf[14] = 4'b1000;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", 64'(flags), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    reset_n = 1'b1;
    @(negedge clock);

    // Latency: exactly three enabled cycles from accept to out_valid.
    cyc(1'b1, 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 1'b1);
    check("lat_cyc1", 64'(out_valid), 64'd0);
    idle(1'b1);
    check("lat_cyc2", 64'(out_valid), 64'd0);
    idle(1'b1);
    check("lat_cyc3", 64'(out_valid), 64'd1);
    drain("latency");

    // Back-to-back stream at full throughput.
    for (int i = 0; i < 15; i++) cyc(1'b1, va[i], vb[i], vr[i], vf[i], 1'b1);
    drain("stream");

    // Backpressure: only three accepted while out_ready is low, head result held.
    cyc(1'b1, 32'h40000000, 32'h40000000, 32'h40800000, 4'b0000, 1'b0);
    cyc(1'b1, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000, 1'b0);
    cyc(1'b1, 32'hC0000000, 32'h3F000000, 32'hBF800000, 4'b0000, 1'b0);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_accepted", 64'(exp_q.size()), 64'd3);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 32'h40400000, 32'h40400000, 32'h41100000, 4'b0000, 1'b0);
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_result", 64'(result), 64'h40800000);
      check("bp_hold_queue", 64'(exp_q.size()), 64'd3);
    end
    cyc(1'b1, 32'h40400000, 32'h40400000, 32'h41100000, 4'b0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("bp_rate_valid", 64'(out_valid), 64'd1);
      idle(1'b1);
    end
    check("bp_all_retired", 64'(exp_q.size()), 64'd0);
    check("bp_empty", 64'(out_valid), 64'd0);

    // Reset with two ops in flight.
    cyc(1'b1, 32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 1'b0);
    cyc(1'b1, 32'h40000000, 32'h3F800000, 32'h40000000, 4'b0000, 1'b0);
    idle(1'b0);
    idle(1'b0);
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_result", 64'(result), 64'd0);
    check("async_rst_flags", 64'(flags), 64'd0);
    exp_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle(1'b1);
      check("no_stale", 64'(out_valid), 64'd0);
    end
    cyc(1'b1, 32'h40000000, 32'h40000000, 32'h40800000, 4'b0000, 1'b1);
    drain("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
